// File: rtl/video_timing_gen.sv
// ---------------------------------------------------------------------------
// video_timing_gen
//
// Raster timing generator. It walks a column/row position through each line
// in the order active, front porch, sync, back porch, and through each frame
// in the same order. The line period is H_TOTAL enabled clocks and the frame
// period is V_TOTAL lines. Every output is a register. Each output is decoded
// from the position that the counters are about to hold, so the decode always
// matches the counts presented in the same cycle, with no pipeline lag.
//
// Ports
//   i_Clk         single clock
//   i_Rst_n       synchronous active-low reset
//   i_Pix_En      pixel clock enable; with it low, everything holds
//   i_Restart     jump to the frame origin (0,0); the frame counter holds
//   o_Col_Count   current column (0 = first visible pixel)
//   o_Row_Count   current row    (0 = first visible line)
//   o_Active      current position is visible
//   o_HSync       horizontal sync, asserted level H_SYNC_POL
//   o_VSync       vertical sync, asserted level V_SYNC_POL, full-line width
//   o_Line_Start  column is 0 (level; qualify with i_Pix_En)
//   o_Frame_Start column and row are both 0 (level; qualify with i_Pix_En)
//   o_Frame_Count completed frames, modulo 2^FRAME_W
// ---------------------------------------------------------------------------
module video_timing_gen #(
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter int H_SYNC_POL = 0,
    parameter int V_SYNC_POL = 0,
    parameter int CNT_W      = 10,
    parameter int FRAME_W    = 8
) (
    input  logic               i_Clk,
    input  logic               i_Rst_n,
    input  logic               i_Pix_En,
    input  logic               i_Restart,
    output logic [CNT_W-1:0]   o_Col_Count,
    output logic [CNT_W-1:0]   o_Row_Count,
    output logic               o_Active,
    output logic               o_HSync,
    output logic               o_VSync,
    output logic               o_Line_Start,
    output logic               o_Frame_Start,
    output logic [FRAME_W-1:0] o_Frame_Count
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // Reject geometries the counters cannot represent and zero-width syncs.
    if (H_TOTAL > (1 << CNT_W)) begin : g_bad_h_total
        $error("video_timing_gen: H_TOTAL does not fit in CNT_W bits");
    end
    if (V_TOTAL > (1 << CNT_W)) begin : g_bad_v_total
        $error("video_timing_gen: V_TOTAL does not fit in CNT_W bits");
    end
    if (H_SYNC == 0 || V_SYNC == 0) begin : g_bad_sync
        $error("video_timing_gen: sync widths must be non-zero");
    end

    // The decode compares one bit wider than the counters. A boundary such
    // as the end of sync can equal 2^CNT_W, and that value must not wrap to 0.
    localparam logic [CNT_W:0] H_ACT_X   = (CNT_W+1)'(H_ACTIVE);
    localparam logic [CNT_W:0] H_SYNC_LO = (CNT_W+1)'(H_ACTIVE + H_FP);
    localparam logic [CNT_W:0] H_SYNC_HI = (CNT_W+1)'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W:0] V_ACT_X   = (CNT_W+1)'(V_ACTIVE);
    localparam logic [CNT_W:0] V_SYNC_LO = (CNT_W+1)'(V_ACTIVE + V_FP);
    localparam logic [CNT_W:0] V_SYNC_HI = (CNT_W+1)'(V_ACTIVE + V_FP + V_SYNC);

    localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);
    localparam logic             HS_ON  = 1'(H_SYNC_POL);
    localparam logic             VS_ON  = 1'(V_SYNC_POL);

    logic [CNT_W-1:0]   r_col;
    logic [CNT_W-1:0]   r_row;
    logic [FRAME_W-1:0] r_frame;
    logic               r_active;
    logic               r_hsync;
    logic               r_vsync;
    logic               r_line_start;
    logic               r_frame_start;

    logic [CNT_W-1:0]   w_col_nxt;
    logic [CNT_W-1:0]   w_row_nxt;
    logic [FRAME_W-1:0] w_frame_nxt;
    logic [CNT_W:0]     w_col_x;
    logic [CNT_W:0]     w_row_x;
    logic               w_active_nxt;
    logic               w_hsync_nxt;
    logic               w_vsync_nxt;

    // Next position. A restart wins over the pixel enable, and reset wins over
    // both, because reset is applied in the register process.
    always_comb begin
        // NOTE: every output of this block is given a hold value first, so no
        // path through the branches can leave one unassigned and infer a latch.
        w_col_nxt   = r_col;
        w_row_nxt   = r_row;
        w_frame_nxt = r_frame;
        if (i_Restart) begin
            w_col_nxt = '0;
            w_row_nxt = '0;
        end else if (i_Pix_En) begin
            if (r_col == H_LAST) begin
                w_col_nxt = '0;
                if (r_row == V_LAST) begin
                    w_row_nxt   = '0;
                    w_frame_nxt = r_frame + FRAME_W'(1);
                end else begin
                    w_row_nxt = r_row + CNT_W'(1);
                end
            end else begin
                w_col_nxt = r_col + CNT_W'(1);
            end
        end
    end

    // Decode the position that the counters are about to take. The decoded
    // flags are then registered on the same edge as the counters.
    always_comb begin
        w_col_x      = {1'b0, w_col_nxt};
        w_row_x      = {1'b0, w_row_nxt};
        w_active_nxt = (w_col_x < H_ACT_X) && (w_row_x < V_ACT_X);
        w_hsync_nxt  = ((w_col_x >= H_SYNC_LO) && (w_col_x < H_SYNC_HI)) ? HS_ON : ~HS_ON;
        w_vsync_nxt  = ((w_row_x >= V_SYNC_LO) && (w_row_x < V_SYNC_HI)) ? VS_ON : ~VS_ON;
    end

    always_ff @(posedge i_Clk) begin
        // NOTE: state is updated with non-blocking assignments. Every register
        // samples its old value on the edge, so the order of statements below
        // does not matter.
        if (!i_Rst_n) begin
            r_col         <= '0;
            r_row         <= '0;
            r_frame       <= '0;
            r_active      <= 1'b1;
            r_hsync       <= ~HS_ON;
            r_vsync       <= ~VS_ON;
            r_line_start  <= 1'b1;
            r_frame_start <= 1'b1;
        end else begin
            r_col         <= w_col_nxt;
            r_row         <= w_row_nxt;
            r_frame       <= w_frame_nxt;
            r_active      <= w_active_nxt;
            r_hsync       <= w_hsync_nxt;
            r_vsync       <= w_vsync_nxt;
            r_line_start  <= (w_col_nxt == '0);
            r_frame_start <= (w_col_nxt == '0) && (w_row_nxt == '0);
        end
    end

    assign o_Col_Count   = r_col;
    assign o_Row_Count   = r_row;
    assign o_Frame_Count = r_frame;
    assign o_Active      = r_active;
    assign o_HSync       = r_hsync;
    assign o_VSync       = r_vsync;
    assign o_Line_Start  = r_line_start;
    assign o_Frame_Start = r_frame_start;

endmodule

// File: tb/tb_video_timing_gen.sv
// ---------------------------------------------------------------------------
// tb_video_timing_gen
//
// Directed bench with three instances:
//   u_a  default 640x480 timing (line, enable, restart and reset behaviour)
//   u_b  tiny 8x5 raster, H_SYNC_POL=1, FRAME_W=2 (frame counter wrap)
//   u_c  8-column lines with the default vertical timing (vsync and frame
//        origin, reachable in a few thousand cycles)
// Each instance is held in reset until its own phase.
// ---------------------------------------------------------------------------
module tb_video_timing_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // ---- instance A: defaults --------------------------------------------
    logic       a_rst_n, a_en, a_restart;
    logic [9:0] a_col, a_row;
    logic [7:0] a_frame;
    logic       a_active, a_hs, a_vs, a_ls, a_fs;

    video_timing_gen u_a (
        .i_Clk(clk), .i_Rst_n(a_rst_n), .i_Pix_En(a_en), .i_Restart(a_restart),
        .o_Col_Count(a_col), .o_Row_Count(a_row), .o_Active(a_active),
        .o_HSync(a_hs), .o_VSync(a_vs), .o_Line_Start(a_ls),
        .o_Frame_Start(a_fs), .o_Frame_Count(a_frame)
    );

    // ---- instance B: tiny raster -----------------------------------------
    logic       b_rst_n, b_en, b_restart;
    logic [9:0] b_col, b_row;
    logic [1:0] b_frame;
    logic       b_active, b_hs, b_vs, b_ls, b_fs;

    video_timing_gen #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(2), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .H_SYNC_POL(1), .FRAME_W(2)
    ) u_b (
        .i_Clk(clk), .i_Rst_n(b_rst_n), .i_Pix_En(b_en), .i_Restart(b_restart),
        .o_Col_Count(b_col), .o_Row_Count(b_row), .o_Active(b_active),
        .o_HSync(b_hs), .o_VSync(b_vs), .o_Line_Start(b_ls),
        .o_Frame_Start(b_fs), .o_Frame_Count(b_frame)
    );

    // ---- instance C: short lines, default vertical -----------------------
    logic       c_rst_n, c_en, c_restart;
    logic [9:0] c_col, c_row;
    logic [7:0] c_frame;
    logic       c_active, c_hs, c_vs, c_ls, c_fs;

    video_timing_gen #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1)
    ) u_c (
        .i_Clk(clk), .i_Rst_n(c_rst_n), .i_Pix_En(c_en), .i_Restart(c_restart),
        .o_Col_Count(c_col), .o_Row_Count(c_row), .o_Active(c_active),
        .o_HSync(c_hs), .o_VSync(c_vs), .o_Line_Start(c_ls),
        .o_Frame_Start(c_fs), .o_Frame_Count(c_frame)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one clock edge, then settle 1 ns before the caller samples.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int ec, er, ef, en_cnt;

    initial begin
        a_rst_n = 1'b0; a_en = 1'b1; a_restart = 1'b0;
        b_rst_n = 1'b0; b_en = 1'b1; b_restart = 1'b0;
        c_rst_n = 1'b0; c_en = 1'b1; c_restart = 1'b0;
        repeat (3) tick();

        // ---- reset values ------------------------------------------------
        check("rst_col",    a_col,    0);
        check("rst_row",    a_row,    0);
        check("rst_frame",  a_frame,  0);
        check("rst_active", a_active, 1);
        check("rst_ls",     a_ls,     1);
        check("rst_fs",     a_fs,     1);
        check("rst_hs",     a_hs,     1);
        check("rst_vs",     a_vs,     1);
        check("rst_b_hs",   b_hs,     0);

        // ---- one full default line, starting at (0,0) --------------------
        a_rst_n = 1'b1;
        for (int k = 1; k <= 800; k++) begin
            tick();
            ec = k % 800;
            er = k / 800;
            check("line_col",    a_col,    ec);
            check("line_row",    a_row,    er);
            check("line_hs",     a_hs,     (ec >= 656 && ec <= 751) ? 0 : 1);
            check("line_active", a_active, (ec < 640) ? 1 : 0);
            check("line_ls",     a_ls,     (ec == 0) ? 1 : 0);
        end

        // ---- restart, then toggle the enable every other cycle -----------
        a_en = 1'b0; a_restart = 1'b1;
        tick();
        a_restart = 1'b0;
        check("rs0_col", a_col, 0);
        check("rs0_row", a_row, 0);
        check("rs0_fs",  a_fs,  1);
        en_cnt = 0;
        for (int i = 0; i < 1600; i++) begin
            a_en = (i % 2 == 0);
            tick();
            if (i % 2 == 0) en_cnt++;
            ec = en_cnt % 800;
            er = en_cnt / 800;
            check("half_col", a_col, ec);
            check("half_row", a_row, er);
            check("half_hs",  a_hs,  (ec >= 656 && ec <= 751) ? 0 : 1);
        end
        check("period_col", a_col, 0);
        check("period_row", a_row, 1);

        // ---- restart with the enable low, from (300,1) -------------------
        a_en = 1'b1;
        repeat (300) tick();
        check("pre_rs_col", a_col, 300);
        check("pre_rs_row", a_row, 1);
        a_en = 1'b0; a_restart = 1'b1;
        tick();
        a_restart = 1'b0;
        check("rs_col",    a_col,    0);
        check("rs_row",    a_row,    0);
        check("rs_fs",     a_fs,     1);
        check("rs_ls",     a_ls,     1);
        check("rs_active", a_active, 1);
        check("rs_hs",     a_hs,     1);
        check("rs_frame",  a_frame,  0);

        // ---- reset mid-frame at (123,1) ----------------------------------
        a_en = 1'b1;
        repeat (923) tick();
        check("pre_rst_col", a_col, 123);
        check("pre_rst_row", a_row, 1);
        a_rst_n = 1'b0;
        tick();
        check("mid_rst_col",    a_col,    0);
        check("mid_rst_row",    a_row,    0);
        check("mid_rst_fs",     a_fs,     1);
        check("mid_rst_ls",     a_ls,     1);
        check("mid_rst_active", a_active, 1);
        check("mid_rst_hs",     a_hs,     1);
        check("mid_rst_vs",     a_vs,     1);
        a_rst_n = 1'b1;
        tick();
        check("post_rst_col", a_col, 1);
        check("post_rst_row", a_row, 0);
        check("post_rst_fs",  a_fs,  0);

        // ---- tiny raster: 4 frames of 40 cycles, frame counter wraps ------
        b_rst_n = 1'b1;
        for (int k = 1; k <= 160; k++) begin
            tick();
            ec = k % 8;
            er = (k / 8) % 5;
            ef = (k / 40) % 4;
            check("b_col",    b_col,    ec);
            check("b_row",    b_row,    er);
            check("b_hs",     b_hs,     (ec == 5 || ec == 6) ? 1 : 0);
            check("b_vs",     b_vs,     (er == 3) ? 0 : 1);
            check("b_active", b_active, (ec < 4 && er < 2) ? 1 : 0);
            check("b_frame",  b_frame,  ef);
        end
        check("b_wrap_frame", b_frame, 0);
        check("b_wrap_fs",    b_fs,    1);

        // ---- default vertical timing with 8-column lines -----------------
        c_rst_n = 1'b1;
        for (int k = 1; k <= 4200; k++) begin
            tick();
            ec = k % 8;
            er = (k / 8) % 525;
            check("c_vs", c_vs, (er == 490 || er == 491) ? 0 : 1);
            check("c_fs", c_fs, (ec == 0 && er == 0) ? 1 : 0);
            if (k == 3919) begin
                check("c_r489_row", c_row, 489);
                check("c_r489_col", c_col, 7);
            end
            if (k == 3936) check("c_r492_row", c_row, 492);
        end
        check("c_origin_row",   c_row,   0);
        check("c_origin_col",   c_col,   0);
        check("c_origin_frame", c_frame, 1);

        // Restart with the enable low keeps the frame count.
        repeat (10) tick();
        check("c_pre_rs_col", c_col, 2);
        check("c_pre_rs_row", c_row, 1);
        c_en = 1'b0; c_restart = 1'b1;
        tick();
        c_restart = 1'b0;
        check("c_rs_col",   c_col,   0);
        check("c_rs_row",   c_row,   0);
        check("c_rs_fs",    c_fs,    1);
        check("c_rs_frame", c_frame, 1);

        // Restart together with reset gives the reset values.
        c_en = 1'b1;
        repeat (3) tick();
        c_rst_n = 1'b0; c_restart = 1'b1;
        tick();
        check("c_both_frame", c_frame, 0);
        check("c_both_col",   c_col,   0);
        check("c_both_fs",    c_fs,    1);
        check("c_both_hs",    c_hs,    1);
        check("c_both_vs",    c_vs,    1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/video_timing_gen.md
VIDEO_TIMING_GEN -- requirements
Module: video_timing_gen

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch in pixels
- H_SYNC, 96, horizontal sync width in pixels
- H_BP, 48, horizontal back porch in pixels
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch in lines
- V_SYNC, 2, vertical sync width in lines
- V_BP, 33, vertical back porch in lines
- H_SYNC_POL, 0, asserted level of o_HSync (0 = active-low)
- V_SYNC_POL, 0, asserted level of o_VSync
- CNT_W, 10, width of the column and row counters
- FRAME_W, 8, width of the frame counter
REQ-002 Derived values SHALL be H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP and V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP.
REQ-003 Ports SHALL be, one per line (name, direction, width, meaning):
- i_Clk, in, 1, single clock
- i_Rst_n, in, 1, reset, synchronous, active-low
- i_Pix_En, in, 1, pixel clock enable
- i_Restart, in, 1, synchronous resync to the frame origin
- o_Col_Count, out, CNT_W, current column
- o_Row_Count, out, CNT_W, current row
- o_Active, out, 1, current position is visible
- o_HSync, out, 1, horizontal sync
- o_VSync, out, 1, vertical sync
- o_Line_Start, out, 1, column is 0
- o_Frame_Start, out, 1, column and row are both 0
- o_Frame_Count, out, FRAME_W, completed-frame counter
REQ-004 The design SHALL use one clock (i_Clk), and its reset (i_Rst_n) SHALL be synchronous and active-low.

Function
REQ-005 Each line SHALL be ordered active, front porch, sync, back porch; column 0 is the first active pixel. Frames SHALL use the same order; row 0 is the first active line.
REQ-006 The counters SHALL advance only on edges where i_Pix_En=1. With i_Pix_En=0, all registers SHALL hold.
REQ-007 On an enabled edge, o_Col_Count SHALL increment.
- At column H_TOTAL-1, o_Col_Count SHALL wrap to 0 and o_Row_Count SHALL increment.
- At the wrap from (H_TOTAL-1, V_TOTAL-1), o_Row_Count SHALL wrap to 0 and o_Frame_Count SHALL increment modulo 2^FRAME_W.
REQ-008 All outputs SHALL be registers updated on the same edge as the counters. In every cycle they SHALL equal the decode of the currently presented counts, with zero lag.
REQ-009 o_Active SHALL be 1 when col < H_ACTIVE and row < V_ACTIVE, else 0.
REQ-010 o_HSync SHALL equal H_SYNC_POL when H_ACTIVE+H_FP <= col < H_ACTIVE+H_FP+H_SYNC, else ~H_SYNC_POL.
REQ-011 o_VSync SHALL equal V_SYNC_POL when V_ACTIVE+V_FP <= row < V_ACTIVE+V_FP+V_SYNC, for the full width of those lines, else ~V_SYNC_POL.
REQ-012 o_Line_Start SHALL be 1 when col==0. o_Frame_Start SHALL be 1 when col==0 and row==0. Both are level decodes; consumers qualify them with i_Pix_En.
REQ-013 When i_Restart=1 on an edge, the counters SHALL load (0,0) regardless of i_Pix_En, outputs SHALL decode (0,0), and o_Frame_Count SHALL hold.
REQ-014 Priority SHALL be reset > i_Restart > i_Pix_En.
REQ-015 If H_TOTAL or V_TOTAL exceeds 2^CNT_W, elaboration SHALL fail. Any zero sync width SHALL also fail elaboration.
REQ-016 Counters SHALL never present a value >= H_TOTAL or >= V_TOTAL.

Reset
REQ-017 While i_Rst_n=0 at an edge, the block SHALL present the following values:
- o_Col_Count=0, o_Row_Count=0, o_Frame_Count=0
- o_Active=1, o_Line_Start=1, o_Frame_Start=1
- o_HSync=~H_SYNC_POL, o_VSync=~V_SYNC_POL
REQ-018 Reset asserted mid-line or mid-frame SHALL take effect on that edge with no residual state. Counting SHALL resume on the first enabled edge after release.

Verification
REQ-019 Defaults, i_Pix_En=1, reset released -> o_HSync low for cols 656..751 only, o_Active low from col 640, col wraps 799->0 with the row incrementing.
REQ-020 Defaults, run to row 489/col 799 -> next edge o_VSync low, held for rows 490..491, high at row 492 col 0, o_Frame_Start at (0,0) after row 524.
REQ-021 i_Pix_En toggled every other cycle -> line period exactly 1600 cycles; all outputs hold on disabled cycles.
REQ-022 i_Restart pulsed at (300,200) with i_Pix_En=0 -> next cycle (0,0), o_Frame_Start=1, o_Frame_Count unchanged. Restart and reset together -> reset values.
REQ-023 Parameters H_ACTIVE=4, H_FP=1, H_SYNC=2, H_BP=1, V_ACTIVE=2, V_FP=1, V_SYNC=1, V_BP=1, H_SYNC_POL=1, FRAME_W=2 -> o_HSync high at cols 5..6, o_Frame_Count wraps 3->0 after 4 frames of 40 cycles.
REQ-024 Reset mid-frame at (123,45) -> next cycle all REQ-017 values, then counting restarts from (0,0).
